// File: rtl/bp_pkg.sv
// Shared widths, state encoding and saturation bounds for the backprop weight-update stage.
// Optional build macro BP_ROUND_EN is consumed by bp_weight_step.
package bp_pkg;

    localparam int N_IN     = 8;
    localparam int XW       = 10;
    localparam int WW       = 8;
    localparam int FW       = 23;
    localparam int TW       = 4;
    localparam int ERRW     = 24;
    localparam int PRODW    = 35;
    localparam int LR_SHIFT = 12;
    localparam int IDXW     = 3;

    localparam logic [WW-1:0] WMAX = {WW{1'b1}};
    localparam logic [WW-1:0] WMIN = {WW{1'b0}};

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_LOAD   = 2'd1;
    localparam state_t S_UPDATE = 2'd2;
    localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/bp_weight_step.sv
// Combinational single-weight step: nw = sat(w - ((err * x) >>> LR_SHIFT)).
// BP_ROUND_EN defined: the shift rounds half up instead of flooring.
module bp_weight_step
    import bp_pkg::*;
(
    input  logic signed [ERRW-1:0] err,
    input  logic        [XW-1:0]   x,
    input  logic        [WW-1:0]   w,
    output logic        [WW-1:0]   nw
);

    logic signed [PRODW-1:0] err_ext;
    logic signed [PRODW-1:0] x_ext;
    logic signed [PRODW-1:0] prod;
    logic signed [PRODW-1:0] prod_adj;
    logic signed [PRODW-1:0] delta;
    logic signed [PRODW-1:0] diff;

    assign err_ext = {{(PRODW-ERRW){err[ERRW-1]}}, err};
    assign x_ext   = $signed({{(PRODW-XW){1'b0}}, x});
    assign prod    = err_ext * x_ext;

`ifdef BP_ROUND_EN
    localparam logic signed [PRODW-1:0] HALF = PRODW'(2**(LR_SHIFT-1));
    assign prod_adj = prod + HALF;
`else
    assign prod_adj = prod;
`endif

    assign delta = prod_adj >>> LR_SHIFT;
    assign diff  = $signed({{(PRODW-WW){1'b0}}, w}) - delta;

    // Clamp the updated weight into the unsigned 1.7 range.
    always_comb begin
        nw = diff[WW-1:0];
        if (diff[PRODW-1])
            nw = WMIN;
        else if (|diff[PRODW-2:WW])
            nw = WMAX;
    end

endmodule

// File: rtl/bp_weight_update.sv
// Backprop weight-update stage: captures a prediction/target/input/weight set, then
// updates one weight per cycle and publishes the whole vector at once in DONE.
// Optional build macro BP_ROUND_EN (round-half-up delta, applied in bp_weight_step).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start_i; inputs captured on the accepting edge
// S_LOAD   | err = final - target registered; err==0 skips straight to DONE
// S_UPDATE | one weight per cycle, idx 0..N_IN-1
// S_DONE   | weights_o valid, done_o pulse, zero_grad_o if err was zero
module bp_weight_update
    import bp_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [FW-1:0]        final_i,
    input  logic [TW-1:0]        target_i,
    input  logic [N_IN*XW-1:0]   x_i,
    input  logic [N_IN*WW-1:0]   weights_i,
    output logic [N_IN*WW-1:0]   weights_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 zero_grad_o
);

    state_t                  state;
    logic [FW-1:0]           final_q;
    logic [TW-1:0]           target_q;
    logic [N_IN*XW-1:0]      x_q;
    logic [N_IN*WW-1:0]      work_q;
    logic [N_IN*WW-1:0]      work_upd;
    logic signed [ERRW-1:0]  err_q;
    logic signed [ERRW-1:0]  err_next;
    logic [IDXW-1:0]         idx_q;
    logic [XW-1:0]           x_sel;
    logic [WW-1:0]           w_sel;
    logic [WW-1:0]           nw;

    assign err_next = $signed({1'b0, final_q}) - $signed({{(ERRW-TW){1'b0}}, target_q});
    assign x_sel    = x_q[int'(idx_q)*XW +: XW];
    assign w_sel    = work_q[int'(idx_q)*WW +: WW];

    bp_weight_step u_step (
        .err (err_q),
        .x   (x_sel),
        .w   (w_sel),
        .nw  (nw)
    );

    // Working vector with the current slot replaced, so the last write can go
    // straight to weights_o on the edge that enters DONE.
    always_comb begin
        work_upd = work_q;
        work_upd[int'(idx_q)*WW +: WW] = nw;
    end

    // Sequencer, capture registers, working vector and output register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            final_q   <= '0;
            target_q  <= '0;
            x_q       <= '0;
            work_q    <= '0;
            err_q     <= '0;
            idx_q     <= '0;
            weights_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        final_q  <= final_i;
                        target_q <= target_i;
                        x_q      <= x_i;
                        work_q   <= weights_i;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    err_q <= err_next;
                    idx_q <= '0;
                    if (err_next == '0) begin
                        weights_o <= work_q;
                        state     <= S_DONE;
                    end else begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    work_q <= work_upd;
                    idx_q  <= idx_q + 1'b1;
                    if (idx_q == IDXW'(N_IN-1)) begin
                        weights_o <= work_upd;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state == S_LOAD) || (state == S_UPDATE);
    assign done_o      = (state == S_DONE);
    assign zero_grad_o = (state == S_DONE) && (err_q == '0);

endmodule
